// File: rtl/sigdelay_pkg.sv
// Shared defaults and FSM state type for the programmable sample delay line.
package sigdelay_pkg;
  localparam int unsigned A_WIDTH_DEF = 9;
  localparam int unsigned D_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_e;
endpackage

// File: rtl/sigdelay_ram2port.sv
// Sample buffer: one write port, one registered read port, write-first on address collision.
// No reset; contents are only ever exposed through the valid-gated output of sigdelay.
module ram2port #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] waddr_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  input  logic               re_i,
  input  logic [A_WIDTH-1:0] raddr_i,
  output logic [D_WIDTH-1:0] rdata_o
);
  logic [D_WIDTH-1:0] mem_q [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    // Same-address bypass gives the zero-delay write-through path.
    if (re_i) rdata_o <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end
endmodule

// File: rtl/sigdelay.sv
// Delay line: output is the sample accepted `offset` strobes earlier, one clock after the strobe.
// valid only rises once enough samples have been accepted since reset or the last offset change.
module sigdelay
  import sigdelay_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [A_WIDTH-1:0] offset,
  input  logic [D_WIDTH-1:0] mic_signal,
  output logic [D_WIDTH-1:0] delayed_signal,
  output logic               valid
);
  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic [A_WIDTH-1:0] offset_q;
  logic               valid_q, valid_d;
  logic [A_WIDTH-1:0] rd_addr;
  logic [D_WIDTH-1:0] rd_data;
  logic               off_chg;

  assign rd_addr = wr_addr_q - offset;
  assign off_chg = (offset != offset_q);

  ram2port #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) u_buf (
    .clk     (clk),
    .we_i    (en),
    .waddr_i (wr_addr_q),
    .wdata_i (mic_signal),
    .re_i    (en),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    wr_addr_d = en ? wr_addr_q + A_WIDTH'(1) : wr_addr_q;
    unique case (state_q)
      EMPTY: begin
        if (en) begin
          if (offset == '0) begin
            state_d = RUN;
            valid_d = 1'b1;
          end else begin
            state_d = FILL;
            cnt_d   = A_WIDTH'(1);
          end
        end
      end
      FILL, RUN: begin
        if (off_chg) begin
          // A strobe coinciding with the change is the first sample of the new fill.
          valid_d = 1'b0;
          if (offset == '0) begin
            state_d = RUN;
            cnt_d   = '0;
            valid_d = en;
          end else begin
            state_d = FILL;
            cnt_d   = en ? A_WIDTH'(1) : '0;
          end
        end else if (en) begin
          if (state_q == RUN) begin
            valid_d = 1'b1;
          end else if (cnt_q == offset) begin
            state_d = RUN;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + A_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = EMPTY;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      offset_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
      offset_q  <= offset;
      valid_q   <= valid_d;
    end
  end

  // The buffer's read register holds between strobes; valid_q gates it so reset clears it at once.
  assign delayed_signal = valid_q ? rd_data : '0;
  assign valid          = valid_q;
endmodule

// File: tb/tb_sigdelay.sv
module tb_sigdelay;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [AW-1:0] offset = '0;
  logic [DW-1:0] mic_signal = '0;
  logic [DW-1:0] delayed_signal;
  logic          valid;

  sigdelay #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .offset         (offset),
    .mic_signal     (mic_signal),
    .delayed_signal (delayed_signal),
    .valid          (valid)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: full history of accepted samples and samples seen since the last refill start.
  int hist[$];
  int fill;
  int prev_off;
  int exp_valid;
  int exp_out;

  task automatic model_reset();
    hist.delete();
    fill      = 0;
    prev_off  = 0;
    exp_valid = 0;
    exp_out   = 0;
  endtask

  task automatic model_step(input bit e, input int o, input int m);
    if (o != prev_off) begin
      fill      = 0;
      exp_valid = 0;
      exp_out   = 0;
    end
    if (e) begin
      hist.push_back(m);
      if (fill >= o) begin
        exp_valid = 1;
        exp_out   = hist[hist.size() - 1 - o];
      end else begin
        exp_valid = 0;
        exp_out   = 0;
        fill++;
      end
    end
    prev_off = o;
  endtask

  task automatic step(input string tag, input bit e, input int o, input int m);
    @(negedge clk);
    en         = e;
    offset     = AW'(o);
    mic_signal = DW'(m);
    @(posedge clk);
    #1;
    model_step(e, o, m);
    chk({tag, "_valid"}, 32'(valid), 32'(exp_valid));
    chk({tag, "_dly"}, 32'(delayed_signal), 32'(exp_out));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_dly", 32'(delayed_signal), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // offset 4, ramp input: first valid output is sample 1 after the fifth strobe
    for (int i = 1; i <= 5; i++) step("ramp4", 1'b1, 4, i);
    chk("ramp4_first_valid", 32'(valid), 32'd1);
    chk("ramp4_first_dly", 32'(delayed_signal), 32'd1);
    for (int i = 6; i <= 12; i++) step("ramp4", 1'b1, 4, i);
    chk("ramp4_track", 32'(delayed_signal), 32'd8);

    // offset 4 -> 2 with a strobe in the change cycle, then refill
    step("chg2", 1'b1, 2, 13);
    chk("chg2_drop", 32'(valid), 32'd0);
    step("chg2", 1'b1, 2, 14);
    step("chg2", 1'b1, 2, 15);
    chk("chg2_back", 32'(valid), 32'd1);
    chk("chg2_val", 32'(delayed_signal), 32'd13);

    // zero offset write-through
    step("zero", 1'b1, 0, 8'hA5);
    chk("zero_dly", 32'(delayed_signal), 32'hA5);
    chk("zero_valid", 32'(valid), 32'd1);

    // maximum offset across several address wraps
    for (int i = 0; i < 40; i++) step("wrap15", 1'b1, 15, 100 + i);
    chk("wrap15_last", 32'(delayed_signal), 32'(139 - 15));

    // sparse strobes: output moves only on strobe cycles
    for (int i = 0; i < 30; i++) step("sparse", (i % 3) == 0, 3, 200 + i);

    // asynchronous reset mid-run
    chk("arst_pre_valid", 32'(valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_dly", 32'(delayed_signal), 32'd0);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) step("refill", 1'b1, 3, 50 + i);

    // randomized traffic with occasional offset changes
    begin
      int o;
      o = 5;
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(39) == 0) o = $urandom_range(15);
        step("rand", $urandom_range(9) < 7, o, $urandom_range(255));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
